wb_cmd_master: RTL and testbench

// - Wishbone classic initiator: turns one command from a valid/ready request port into one single-beat

---
 rtl/wb_cmd_master_pkg.sv | 14 +
 rtl/wb_cmd_master.sv | 168 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared types and Wishbone bus widths for the command-driven Wishbone initiator.
package wb_cmd_master_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one single-beat bus cycle.
// Latency: bus signals 1 cycle after accept, response 1 cycle after ack (or TIMEOUT cycles with no ack).
// Backpressure: one transaction in flight; cmd_ready stays low until the response has been taken.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned        TIMEOUT  = 255,
    parameter logic [DAT_W-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADR_W-1:0]  cmd_adr,
    input  logic [DAT_W-1:0]  cmd_dat,
    input  logic [SEL_W-1:0]  cmd_sel,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DAT_W-1:0]  rsp_dat,
    output logic              rsp_err,

    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [ADR_W-1:0]  wbm_adr_o,
    output logic [DAT_W-1:0]  wbm_dat_o,
    input  logic [DAT_W-1:0]  wbm_dat_i,
    input  logic              wbm_ack_i,

    output logic              busy
);

    localparam int              CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               timeout_hit;

    logic               cyc_q,    cyc_nxt;
    logic               we_q,     we_nxt;
    logic [SEL_W-1:0]   sel_q,    sel_nxt;
    logic [ADR_W-1:0]   adr_q,    adr_nxt;
    logic [DAT_W-1:0]   dat_o_q,  dat_o_nxt;
    logic               rvld_q,   rvld_nxt;
    logic [DAT_W-1:0]   rdat_q,   rdat_nxt;
    logic               rerr_q,   rerr_nxt;
    logic               busy_q,   busy_nxt;

    assign timeout_hit = TO_EN && (cnt == TO_LAST);
    assign cmd_ready   = (state == IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid)                   state_nxt = BUS;
            BUS:     if (wbm_ack_i || timeout_hit)    state_nxt = RESP;
            RESP:    if (rsp_ready)                   state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cyc_nxt   = cyc_q;
        we_nxt    = we_q;
        sel_nxt   = sel_q;
        adr_nxt   = adr_q;
        dat_o_nxt = dat_o_q;
        rvld_nxt  = rvld_q;
        rdat_nxt  = rdat_q;
        rerr_nxt  = rerr_q;
        cnt_nxt   = cnt;
        busy_nxt  = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    cyc_nxt   = 1'b1;
                    we_nxt    = cmd_we;
                    sel_nxt   = cmd_sel;
                    adr_nxt   = cmd_adr;
                    dat_o_nxt = cmd_dat;
                end
            end
            BUS: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (wbm_ack_i) begin
                    cyc_nxt  = 1'b0;
                    rvld_nxt = 1'b1;
                    rdat_nxt = we_q ? '0 : wbm_dat_i;
                    rerr_nxt = 1'b0;
                end else begin
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                    if (timeout_hit) begin
                        cyc_nxt  = 1'b0;
                        rvld_nxt = 1'b1;
                        rdat_nxt = ERR_DATA;
                        rerr_nxt = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvld_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
            end
            default: begin
                cyc_nxt  = 1'b0;
                rvld_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_o_q <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= '0;
            rerr_q  <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_nxt;
            we_q    <= we_nxt;
            sel_q   <= sel_nxt;
            adr_q   <= adr_nxt;
            dat_o_q <= dat_o_nxt;
            rvld_q  <= rvld_nxt;
            rdat_q  <= rdat_nxt;
            rerr_q  <= rerr_nxt;
            cnt     <= cnt_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_o_q;
    assign rsp_valid = rvld_q;
    assign rsp_dat   = rdat_q;
    assign rsp_err   = rerr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with TIMEOUT=8.
module tb_wb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for exactly one edge while the block is idle.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b/%b expected 0/0", cyc, stb); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b/%b expected 0/0", rsp_valid, rsp_err); end
        checks++; if (rsp_dat !== 32'h0 || adr !== 32'h0 || dat_o !== 32'h0 || sel !== 4'h0 || we !== 1'b0) begin
            errors++; $display("FAIL reset_regs: rsp_dat=%h adr=%h dat_o=%h sel=%h we=%b expected all 0", rsp_dat, adr, dat_o, sel, we); end
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready: got ready=%b busy=%b expected 1/0", cmd_ready, busy); end
    endtask

    task automatic test_write();
        issue(1'b1, 32'h2100_0000, 32'h0000_0001, 4'hF);
        checks++; if (cyc !== 1'b1 || stb !== 1'b1 || we !== 1'b1 || adr !== 32'h2100_0000 || sel !== 4'hF || dat_o !== 32'h1) begin
            errors++; $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h expected 1 1 1 21000000 f 00000001", cyc, stb, we, adr, sel, dat_o); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL write_busy: ready=%b busy=%b expected 0/1", cmd_ready, busy); end
        step();
        checks++; if (cyc !== 1'b1 || dat_o !== 32'h1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL write_hold: cyc=%b dat=%h rsp_valid=%b expected 1 00000001 0", cyc, dat_o, rsp_valid); end
        ack = 1'b1; dat_i = 32'h1234_5678;
        step();
        ack = 1'b0;
        checks++; if (cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
            errors++; $display("FAIL write_rsp: cyc=%b valid=%b err=%b dat=%h expected 0 1 0 00000000", cyc, rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL write_done: valid=%b ready=%b busy=%b expected 0 1 0", rsp_valid, cmd_ready, busy); end
    endtask

    task automatic test_read();
        issue(1'b0, 32'h2100_0004, 32'hFFFF_FFFF, 4'hF);
        checks++; if (cyc !== 1'b1 || we !== 1'b0 || adr !== 32'h2100_0004) begin
            errors++; $display("FAIL read_bus: cyc=%b we=%b adr=%h expected 1 0 21000004", cyc, we, adr); end
        ack = 1'b1; dat_i = 32'h0000_0001;
        step();
        ack = 1'b0; dat_i = 32'h0;
        checks++; if (cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL read_rsp: cyc=%b valid=%b dat=%h err=%b expected 0 1 00000001 0", cyc, rsp_valid, rsp_dat, rsp_err); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        issue(1'b0, 32'h3000_0000, 32'h0, 4'h1);
        while (cyc === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++; if (n != 8) begin errors++; $display("FAIL timeout_len: cyc high %0d cycles expected 8", n); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL timeout_rsp: valid=%b err=%b dat=%h expected 1 1 deadbeef", rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL timeout_done: valid=%b ready=%b expected 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
        for (int i = 0; i < 7; i++) step();
        checks++; if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL coinc_pre: cyc=%b valid=%b expected 1 0", cyc, rsp_valid); end
        ack = 1'b1; dat_i = 32'h5AA5_0FF0;
        step();
        ack = 1'b0; dat_i = 32'h0;
        checks++; if (cyc !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h5AA5_0FF0) begin
            errors++; $display("FAIL coinc_rsp: cyc=%b valid=%b err=%b dat=%h expected 0 1 0 5aa50ff0", cyc, rsp_valid, rsp_err, rsp_dat); end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        issue(1'b0, 32'h2100_0008, 32'h0, 4'hF);
        ack = 1'b1; dat_i = 32'hCAFE_0001;
        step();
        ack = 1'b0;
        // Second command and stray acks are presented while the response waits.
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h2100_000C; cmd_dat = 32'h77; cmd_sel = 4'h3;
        for (int i = 0; i < 5; i++) begin
            ack = i[0]; dat_i = 32'hBAD0_0000 + i;
            checks++; if (rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_0001 || rsp_err !== 1'b0 || cmd_ready !== 1'b0 || cyc !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: valid=%b dat=%h err=%b ready=%b cyc=%b expected 1 cafe0001 0 0 0",
                                   i, rsp_valid, rsp_dat, rsp_err, cmd_ready, cyc); end
            step();
        end
        ack = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || cyc !== 1'b0) begin
            errors++; $display("FAIL bp_release: valid=%b ready=%b cyc=%b expected 0 1 0", rsp_valid, cmd_ready, cyc); end
        step();
        cmd_valid = 1'b0;
        checks++; if (cyc !== 1'b1 || we !== 1'b1 || adr !== 32'h2100_000C || dat_o !== 32'h77 || sel !== 4'h3) begin
            errors++; $display("FAIL bp_next: cyc=%b we=%b adr=%h dat=%h sel=%h expected 1 1 2100000c 00000077 3", cyc, we, adr, dat_o, sel); end
        ack = 1'b1;
        step();
        ack = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_bus();
        issue(1'b1, 32'h4000_0000, 32'hAB, 4'hF);
        step();
        checks++; if (cyc !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: cyc=%b expected 1", cyc); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid: cyc=%b stb=%b valid=%b expected 0 0 0", cyc, stb, rsp_valid); end
        step();
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after: ready=%b busy=%b valid=%b expected 1 0 0", cmd_ready, busy, rsp_valid); end
    endtask

    task automatic test_stray_ack();
        ack = 1'b1; dat_i = 32'hFFFF_0000;
        step(); step();
        ack = 1'b0;
        checks++; if (cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL stray_ack: cyc=%b valid=%b ready=%b busy=%b err=%b expected 0 0 1 0 0", cyc, rsp_valid, cmd_ready, busy, rsp_err); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_at_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_stray_ack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
